// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: pops requests from a request FIFO, runs one APB transfer per
// request and pushes exactly one response per request into a response FIFO.
//
// Optional feature: define APB_TIMEOUT_EN to enable the ACCESS wait-state
// timeout (TIMEOUT_CYC cycles). Without it ACCESS waits indefinitely.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_fifo_empty/rd_en/rdata       request FIFO, rdata = {wr, sel, addr, wdata}
//   resp_fifo_full/wr_en/wdata       response FIFO, wdata = {timeout, slverr, rdata}
//   psel/penable/pwrite/paddr/pwdata APB request side
//   pready/prdata/pslverr            APB completion side
//   busy                             high whenever the FSM is not IDLE
module apb_master_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SLV     = 4,
  parameter int unsigned TIMEOUT_CYC = 16,
  localparam int unsigned SEL_W      = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1,
  localparam int unsigned REQ_W      = 1 + SEL_W + ADDR_W + DATA_W,
  localparam int unsigned RESP_W     = 2 + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_fifo_empty,
  output logic               req_fifo_rd_en,
  input  logic [REQ_W-1:0]   req_fifo_rdata,
  input  logic               resp_fifo_full,
  output logic               resp_fifo_wr_en,
  output logic [RESP_W-1:0]  resp_fifo_wdata,
  output logic [NUM_SLV-1:0] psel,
  output logic               penable,
  output logic               pwrite,
  output logic [ADDR_W-1:0]  paddr,
  output logic [DATA_W-1:0]  pwdata,
  input  logic               pready,
  input  logic [DATA_W-1:0]  prdata,
  input  logic               pslverr,
  output logic               busy
);

  // Elaboration-time parameter range check.
  if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT_CYC < 1) begin : g_param_chk
    $error("apb_master_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FIFO_RREQ = 3'd1,
    SAMPLE    = 3'd2,
    SETUP     = 3'd3,
    ACCESS    = 3'd4,
    RESP_PUSH = 3'd5
  } state_t;

  state_t state_q, state_nx;

  // Request fields as presented by the FIFO.
  logic               req_wr;
  logic [SEL_W-1:0]   req_sel;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic [NUM_SLV-1:0] req_sel_oh;
  logic               req_sel_ok;

  logic [NUM_SLV-1:0] sel_oh_q;
  logic [RESP_W-1:0]  resp_q;
  logic               timeout_hit;

  assign req_wr    = req_fifo_rdata[REQ_W-1];
  assign req_sel   = req_fifo_rdata[ADDR_W+DATA_W +: SEL_W];
  assign req_addr  = req_fifo_rdata[DATA_W +: ADDR_W];
  assign req_wdata = req_fifo_rdata[DATA_W-1:0];

  // One-hot decode; an out-of-range select decodes to all-zero.
  always_comb begin
    req_sel_oh = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (req_sel == SEL_W'(i)) req_sel_oh[i] = 1'b1;
    end
  end
  assign req_sel_ok = |req_sel_oh;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt_q;

  // Counts ACCESS cycles without pready; cleared while in SETUP.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      to_cnt_q <= '0;
    end else if (state_q == ACCESS && !pready) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end

  // This cycle is the TIMEOUT_CYC-th waiting ACCESS cycle.
  assign timeout_hit = (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  // Next-state logic; pready wins over a timeout in the same cycle.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:      if (!req_fifo_empty) state_nx = FIFO_RREQ;
      FIFO_RREQ: state_nx = SAMPLE;
      SAMPLE:    state_nx = req_sel_ok ? SETUP : RESP_PUSH;
      SETUP:     state_nx = ACCESS;
      ACCESS:    if (pready || timeout_hit) state_nx = RESP_PUSH;
      RESP_PUSH: if (!resp_fifo_full) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Output decode from state; the push is qualified by FIFO space.
  always_comb begin
    req_fifo_rd_en  = 1'b0;
    resp_fifo_wr_en = 1'b0;
    psel            = '0;
    penable         = 1'b0;
    busy            = 1'b0;
    if (state_q != IDLE) busy = 1'b1;
    case (state_q)
      FIFO_RREQ: req_fifo_rd_en = 1'b1;
      SETUP:     psel = sel_oh_q;
      ACCESS: begin
        psel    = sel_oh_q;
        penable = 1'b1;
      end
      RESP_PUSH: resp_fifo_wr_en = !resp_fifo_full;
      default: ;
    endcase
  end

  // Request latch and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      sel_oh_q <= '0;
      resp_q   <= '0;
    end else begin
      case (state_q)
        SAMPLE: begin
          pwrite   <= req_wr;
          paddr    <= req_addr;
          pwdata   <= req_wdata;
          sel_oh_q <= req_sel_oh;
          if (!req_sel_ok) resp_q <= {1'b0, 1'b1, DATA_W'(0)};
        end
        ACCESS: begin
          if (pready) begin
            resp_q <= {1'b0, pslverr, (pwrite ? DATA_W'(0) : prdata)};
          end else if (timeout_hit) begin
            resp_q <= {1'b1, 1'b1, DATA_W'(0)};
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_fifo_wdata = resp_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
module tb_apb_master_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        resp_fifo_full;

  // Main instance: 4 slaves
  logic        req_fifo_empty;
  logic        req_fifo_rd_en;
  logic [66:0] req_fifo_rdata;
  logic        resp_fifo_wr_en;
  logic [33:0] resp_fifo_wdata;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        busy;

  // Second instance: 3 slaves, for out-of-range select
  logic        req_fifo_empty3;
  logic        req_fifo_rd_en3;
  logic [66:0] req_fifo_rdata3;
  logic        resp_fifo_wr_en3;
  logic [33:0] resp_fifo_wdata3;
  logic [2:0]  psel3;
  logic        penable3;
  logic        pwrite3;
  logic [31:0] paddr3;
  logic [31:0] pwdata3;
  logic        busy3;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [66:0] GARB = '1;

  always #5 clk = ~clk;

  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .rst(rst),
    .req_fifo_empty(req_fifo_empty), .req_fifo_rd_en(req_fifo_rd_en),
    .req_fifo_rdata(req_fifo_rdata),
    .resp_fifo_full(resp_fifo_full), .resp_fifo_wr_en(resp_fifo_wr_en),
    .resp_fifo_wdata(resp_fifo_wdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .busy(busy)
  );

  apb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(3), .TIMEOUT_CYC(16)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_fifo_empty(req_fifo_empty3), .req_fifo_rd_en(req_fifo_rd_en3),
    .req_fifo_rdata(req_fifo_rdata3),
    .resp_fifo_full(resp_fifo_full), .resp_fifo_wr_en(resp_fifo_wr_en3),
    .resp_fifo_wdata(resp_fifo_wdata3),
    .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3), .pwdata(pwdata3),
    .pready(pready), .prdata(prdata), .pslverr(pslverr), .busy(busy3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge with the FSM in IDLE; returns at the negedge of the
  // SETUP cycle (+3), having checked the pop and that no select precedes it.
  task automatic issue(input logic wr, input logic [1:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_fifo_empty = 1'b0;
    tick();                                   // +1 FIFO_RREQ
    chk("rd_en_at_p1", 64'(req_fifo_rd_en), 64'h1);
    chk("psel_at_p1", 64'(psel), 64'h0);
    req_fifo_empty = 1'b1;
    tick();                                   // +2 SAMPLE, data valid now
    chk("rd_en_at_p2", 64'(req_fifo_rd_en), 64'h0);
    chk("psel_at_p2", 64'(psel), 64'h0);
    req_fifo_rdata = {wr, sel, addr, wdata};
    tick();                                   // +3 SETUP
    req_fifo_rdata = GARB;
  endtask

  initial begin
    logic pushed;
    logic left_access;

    rst             = 1'b1;
    pready          = 1'b0;
    prdata          = 32'h0;
    pslverr         = 1'b0;
    resp_fifo_full  = 1'b0;
    req_fifo_empty  = 1'b1;
    req_fifo_rdata  = GARB;
    req_fifo_empty3 = 1'b1;
    req_fifo_rdata3 = GARB;
    tick();
    tick();

    // Reset state
    chk("rst_psel", 64'(psel), 64'h0);
    chk("rst_penable", 64'(penable), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rd_en", 64'(req_fifo_rd_en), 64'h0);
    chk("rst_wr_en", 64'(resp_fifo_wr_en), 64'h0);
    chk("rst_resp", 64'(resp_fifo_wdata), 64'h0);
    chk("rst_paddr", 64'(paddr), 64'h0);
    chk("rst_pwrite", 64'(pwrite), 64'h0);
    chk("rst_pwdata", 64'(pwdata), 64'h0);
    chk("rst_busy3", 64'(busy3), 64'h0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 64'(busy), 64'h0);

    // Write sel=2, pready immediately
    pready = 1'b1;
    prdata = 32'hDEADBEEF;
    issue(1'b1, 2'd2, 32'h10, 32'hA5A5A5A5);
    chk("wr_psel_p3", 64'(psel), 64'h4);
    chk("wr_penable_p3", 64'(penable), 64'h0);
    chk("wr_paddr_p3", 64'(paddr), 64'h10);
    chk("wr_pwrite_p3", 64'(pwrite), 64'h1);
    chk("wr_pwdata_p3", 64'(pwdata), 64'hA5A5A5A5);
    tick();                                   // +4 ACCESS
    chk("wr_psel_p4", 64'(psel), 64'h4);
    chk("wr_penable_p4", 64'(penable), 64'h1);
    chk("wr_wr_en_p4", 64'(resp_fifo_wr_en), 64'h0);
    tick();                                   // +5 RESP_PUSH
    pready = 1'b0;
    chk("wr_wr_en_p5", 64'(resp_fifo_wr_en), 64'h1);
    chk("wr_resp", 64'(resp_fifo_wdata), 64'h0);
    chk("wr_psel_p5", 64'(psel), 64'h0);
    chk("wr_penable_p5", 64'(penable), 64'h0);
    tick();
    chk("wr_wr_en_p6", 64'(resp_fifo_wr_en), 64'h0);
    chk("wr_busy_p6", 64'(busy), 64'h0);

    // Read sel=0, 3 wait states
    prdata = 32'hFFFF0000;
    issue(1'b0, 2'd0, 32'h20, 32'h0BAD0BAD);
    chk("rd_psel_setup", 64'(psel), 64'h1);
    chk("rd_pwrite", 64'(pwrite), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_wait_penable", 64'(penable), 64'h1);
      chk("rd_wait_paddr", 64'(paddr), 64'h20);
      chk("rd_wait_wr_en", 64'(resp_fifo_wr_en), 64'h0);
    end
    tick();                                   // 4th ACCESS cycle
    chk("rd_acc4_penable", 64'(penable), 64'h1);
    pready = 1'b1;
    prdata = 32'h12345678;
    tick();
    pready = 1'b0;
    prdata = 32'hFFFF0000;
    chk("rd_wr_en", 64'(resp_fifo_wr_en), 64'h1);
    chk("rd_resp", 64'(resp_fifo_wdata), 64'h12345678);
    chk("rd_paddr_end", 64'(paddr), 64'h20);
    tick();
    chk("rd_single_push", 64'(resp_fifo_wr_en), 64'h0);
    chk("rd_idle", 64'(busy), 64'h0);

    // Write sel=1 with slverr, response FIFO full for 5 cycles
    issue(1'b1, 2'd1, 32'h30, 32'h11112222);
    chk("full_psel_setup", 64'(psel), 64'h2);
    pready  = 1'b1;
    pslverr = 1'b1;
    tick();                                   // ACCESS, completes
    resp_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_hold_wr_en", 64'(resp_fifo_wr_en), 64'h0);
      chk("full_hold_busy", 64'(busy), 64'h1);
      pready  = 1'b0;
      pslverr = 1'b0;
    end
    tick();
    resp_fifo_full = 1'b0;
    #1;
    chk("full_push", 64'(resp_fifo_wr_en), 64'h1);
    chk("full_resp", 64'(resp_fifo_wdata), 64'h1_0000_0000);
    tick();
    chk("full_single_push", 64'(resp_fifo_wr_en), 64'h0);
    chk("full_idle", 64'(busy), 64'h0);

    // Out-of-range select on 3-slave instance
    req_fifo_empty3 = 1'b0;
    tick();
    chk("oor_rd_en", 64'(req_fifo_rd_en3), 64'h1);
    req_fifo_empty3 = 1'b1;
    tick();
    req_fifo_rdata3 = {1'b0, 2'd3, 32'h40, 32'h0};
    chk("oor_psel_p2", 64'(psel3), 64'h0);
    tick();
    req_fifo_rdata3 = GARB;
    chk("oor_psel_p3", 64'(psel3), 64'h0);
    chk("oor_penable_p3", 64'(penable3), 64'h0);
    chk("oor_wr_en", 64'(resp_fifo_wr_en3), 64'h1);
    chk("oor_resp", 64'(resp_fifo_wdata3), 64'h1_0000_0000);
    tick();
    chk("oor_psel_p4", 64'(psel3), 64'h0);
    chk("oor_wr_en_after", 64'(resp_fifo_wr_en3), 64'h0);
    chk("oor_idle", 64'(busy3), 64'h0);

    // pready held low
    issue(1'b0, 2'd3, 32'h50, 32'h0);
    chk("to_psel_setup", 64'(psel), 64'h8);
`ifdef APB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("to_wait_penable", 64'(penable), 64'h1);
      chk("to_wait_wr_en", 64'(resp_fifo_wr_en), 64'h0);
    end
    tick();
    chk("to_push", 64'(resp_fifo_wr_en), 64'h1);
    chk("to_resp", 64'(resp_fifo_wdata), 64'h3_0000_0000);
    tick();
    chk("to_idle", 64'(busy), 64'h0);
    issue(1'b0, 2'd1, 32'h60, 32'h0);
    tick();                                   // ACCESS
`else
    pushed      = 1'b0;
    left_access = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (resp_fifo_wr_en) pushed = 1'b1;
      if (!penable) left_access = 1'b0 | 1'b1;
    end
    chk("noto_no_push", 64'(pushed), 64'h0);
    chk("noto_left_access", 64'(left_access), 64'h0);
    chk("noto_penable", 64'(penable), 64'h1);
`endif

    // Reset during ACCESS abandons the transfer
    chk("rst_pre_penable", 64'(penable), 64'h1);
    rst = 1'b1;
    tick();
    chk("rstacc_psel", 64'(psel), 64'h0);
    chk("rstacc_penable", 64'(penable), 64'h0);
    chk("rstacc_busy", 64'(busy), 64'h0);
    chk("rstacc_wr_en", 64'(resp_fifo_wr_en), 64'h0);
    rst    = 1'b0;
    pready = 1'b1;
    pushed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_fifo_wr_en || busy) pushed = 1'b1;
    end
    chk("rstacc_no_resp", 64'(pushed), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
